// File: rtl/axi4l_burst_responder_if.sv
// AXI4-Lite write/read channel bundle used by axi4l_burst_responder.
// master drives requests and response-ready; slave drives the responses.
interface axi4l_burst_responder_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0]   s_awaddr;
  logic                s_awvalid;
  logic                s_awready;
  logic [DATA_W-1:0]   s_wdata;
  logic [DATA_W/8-1:0] s_wstrb;
  logic                s_wvalid;
  logic                s_wready;
  logic [1:0]          s_bresp;
  logic                s_bvalid;
  logic                s_bready;
  logic [ADDR_W-1:0]   s_araddr;
  logic                s_arvalid;
  logic                s_arready;
  logic [DATA_W-1:0]   s_rdata;
  logic [1:0]          s_rresp;
  logic                s_rvalid;
  logic                s_rready;

  modport master (
    output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
    output s_araddr, s_arvalid, s_rready,
    input  s_awready, s_wready, s_bresp, s_bvalid,
    input  s_arready, s_rdata, s_rresp, s_rvalid
  );

  modport slave (
    input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
    input  s_araddr, s_arvalid, s_rready,
    output s_awready, s_wready, s_bresp, s_bvalid,
    output s_arready, s_rdata, s_rresp, s_rvalid
  );
endinterface

// File: rtl/axi4l_burst_responder.sv
// AXI4-Lite responder backed by a local word memory; AW and W are held independently
// and commit together, reads return one cycle after the AR handshake.
module axi4l_burst_responder #(
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned MEM_DEPTH      = 16,
  parameter logic [63:0] BASE_ADDR      = 64'd0,
  parameter int unsigned CNT_WIDTH      = 8
) (
  input  logic                     clk,
  input  logic                     arst,
  input  logic                     run,
  axi4l_burst_responder_if.slave   s_axi,
  output logic [CNT_WIDTH-1:0]     o_wr_count
);

  localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;
  localparam int unsigned IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [AXI_ADDR_WIDTH-1:0] BASE      = AXI_ADDR_WIDTH'(BASE_ADDR);
  localparam logic [AXI_ADDR_WIDTH-1:0] MEM_BYTES = AXI_ADDR_WIDTH'(4 * MEM_DEPTH);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [0:0] RD_IDLE = 1'b0;
  localparam logic [0:0] RD_DATA = 1'b1;

  // Extra MSB captures the borrow so a < BASE needs no constant compare.
  function automatic logic addr_ok(input logic [AXI_ADDR_WIDTH-1:0] a);
    logic [AXI_ADDR_WIDTH:0] off;
    off = {1'b0, a} - {1'b0, BASE};
    return !off[AXI_ADDR_WIDTH] && (off[AXI_ADDR_WIDTH-1:0] < MEM_BYTES) && (a[1:0] == 2'b00);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [AXI_ADDR_WIDTH-1:0] a);
    logic [AXI_ADDR_WIDTH-1:0] off;
    off = a - BASE;
    return IDX_W'(off >> 2);
  endfunction

  logic [AXI_DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  logic                      r_aw_full;
  logic                      r_w_full;
  logic [AXI_ADDR_WIDTH-1:0] r_awaddr;
  logic [AXI_DATA_WIDTH-1:0] r_wdata;
  logic [STRB_W-1:0]         r_wstrb;
  logic                      r_bvalid;
  logic [1:0]                r_bresp;
  logic [CNT_WIDTH-1:0]      r_wr_count;
  logic [0:0]                r_rd_state;
  logic [AXI_DATA_WIDTH-1:0] r_rdata;
  logic [1:0]                r_rresp;

  logic                      w_aw_hs;
  logic                      w_w_hs;
  logic                      w_ar_hs;
  logic                      w_commit;
  logic                      w_wr_ok;
  logic                      w_rd_ok;
  logic [AXI_ADDR_WIDTH-1:0] w_wr_addr;
  logic [AXI_DATA_WIDTH-1:0] w_wr_data;
  logic [STRB_W-1:0]         w_wr_strb;
  logic [IDX_W-1:0]          w_wr_idx;
  logic [IDX_W-1:0]          w_rd_idx;

  assign s_axi.s_awready = arst & ~r_aw_full & ~r_bvalid;
  assign s_axi.s_wready  = arst & ~r_w_full & ~r_bvalid;
  assign s_axi.s_arready = arst & (r_rd_state == RD_IDLE);
  assign s_axi.s_bvalid  = r_bvalid;
  assign s_axi.s_bresp   = r_bresp;
  assign s_axi.s_rvalid  = (r_rd_state == RD_DATA);
  assign s_axi.s_rdata   = r_rdata;
  assign s_axi.s_rresp   = r_rresp;
  assign o_wr_count      = r_wr_count;

  assign w_aw_hs = s_axi.s_awvalid & s_axi.s_awready;
  assign w_w_hs  = s_axi.s_wvalid & s_axi.s_wready;
  assign w_ar_hs = s_axi.s_arvalid & s_axi.s_arready;

  // Commit as soon as both halves are present, including a same-cycle handshake.
  assign w_commit  = arst & (r_aw_full | w_aw_hs) & (r_w_full | w_w_hs);
  assign w_wr_addr = r_aw_full ? r_awaddr : s_axi.s_awaddr;
  assign w_wr_data = r_w_full ? r_wdata : s_axi.s_wdata;
  assign w_wr_strb = r_w_full ? r_wstrb : s_axi.s_wstrb;
  assign w_wr_ok   = addr_ok(w_wr_addr);
  assign w_wr_idx  = word_idx(w_wr_addr);
  assign w_rd_ok   = addr_ok(s_axi.s_araddr);
  assign w_rd_idx  = word_idx(s_axi.s_araddr);

  always_ff @(posedge clk) begin
    if (!arst) begin
      r_aw_full <= 1'b0;
      r_w_full  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
    end else begin
      if (w_commit) begin
        r_aw_full <= 1'b0;
        r_w_full  <= 1'b0;
      end else begin
        if (w_aw_hs) r_aw_full <= 1'b1;
        if (w_w_hs)  r_w_full  <= 1'b1;
      end
      if (w_aw_hs) r_awaddr <= s_axi.s_awaddr;
      if (w_w_hs) begin
        r_wdata <= s_axi.s_wdata;
        r_wstrb <= s_axi.s_wstrb;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!arst) begin
      r_bvalid <= 1'b0;
      r_bresp  <= RESP_OKAY;
    end else if (w_commit) begin
      r_bvalid <= 1'b1;
      r_bresp  <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (r_bvalid && s_axi.s_bready) begin
      r_bvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!arst) begin
      r_wr_count <= '0;
    end else if (!run) begin
      r_wr_count <= '0;
    end else if (w_commit && w_wr_ok) begin
      r_wr_count <= r_wr_count + CNT_WIDTH'(1);
    end
  end

  // Memory is not reset; w_commit is already gated by arst.
  always_ff @(posedge clk) begin
    if (w_commit && w_wr_ok) begin
      for (int b = 0; b < int'(STRB_W); b++) begin
        if (w_wr_strb[b]) r_mem[w_wr_idx][8*b +: 8] <= w_wr_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!arst) begin
      r_rd_state <= RD_IDLE;
      r_rdata    <= '0;
      r_rresp    <= RESP_OKAY;
    end else begin
      case (r_rd_state)
        RD_IDLE: begin
          if (w_ar_hs) begin
            r_rd_state <= RD_DATA;
            r_rdata    <= w_rd_ok ? r_mem[w_rd_idx] : '0;
            r_rresp    <= w_rd_ok ? RESP_OKAY : RESP_SLVERR;
          end
        end
        RD_DATA: begin
          if (s_axi.s_rready) r_rd_state <= RD_IDLE;
        end
        default: r_rd_state <= RD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4l_burst_responder.sv
// Randomised, self-checking bench for axi4l_burst_responder against a word-array model.
module tb_axi4l_burst_responder;
  localparam int unsigned AW    = 64;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned CW    = 8;

  logic          clk = 1'b0;
  logic          arst;
  logic          run;
  logic [CW-1:0] wr_count;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] ref_mem [DEPTH];
  int unsigned ref_cnt = 0;

  axi4l_burst_responder_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  axi4l_burst_responder #(
    .AXI_ADDR_WIDTH(AW),
    .AXI_DATA_WIDTH(DW),
    .MEM_DEPTH     (DEPTH),
    .BASE_ADDR     (64'd0),
    .CNT_WIDTH     (CW)
  ) dut (
    .clk       (clk),
    .arst      (arst),
    .run       (run),
    .s_axi     (bus),
    .o_wr_count(wr_count)
  );

  always #5 clk = ~clk;

  function automatic bit ref_ok(input logic [63:0] a);
    return (a < 64'(4 * DEPTH)) && (a % 4 == 0);
  endfunction

  function automatic logic [1:0] ref_resp(input logic [63:0] a);
    return ref_ok(a) ? 2'b00 : 2'b10;
  endfunction

  function automatic logic [31:0] ref_read(input logic [63:0] a);
    return ref_ok(a) ? ref_mem[int'(a / 4)] : 32'h0;
  endfunction

  task automatic ref_write(input logic [63:0] a, input logic [31:0] d, input logic [3:0] s);
    if (ref_ok(a)) begin
      for (int l = 0; l < 4; l++) if (s[l]) ref_mem[int'(a / 4)][8*l +: 8] = d[8*l +: 8];
      if (run) ref_cnt = (ref_cnt + 1) % 256;
    end
  endtask

  // Caller is at a negedge; returns at a negedge after the B handshake.
  task automatic axi_write(input logic [63:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly,
                           output logic [1:0] resp, output int lat);
    int cyc = 0;
    bit aw_pend = 1'b1;
    bit w_pend = 1'b1;
    bit aw_hs, w_hs;
    bus.s_awaddr = a;
    bus.s_wdata  = d;
    bus.s_wstrb  = s;
    bus.s_bready = 1'b1;
    while ((aw_pend || w_pend) && cyc < 50) begin
      bus.s_awvalid = aw_pend && (cyc >= aw_dly);
      bus.s_wvalid  = w_pend && (cyc >= w_dly);
      aw_hs = bus.s_awvalid && bus.s_awready;
      w_hs  = bus.s_wvalid && bus.s_wready;
      @(negedge clk);
      cyc++;
      if (aw_hs) aw_pend = 1'b0;
      if (w_hs)  w_pend  = 1'b0;
    end
    bus.s_awvalid = 1'b0;
    bus.s_wvalid  = 1'b0;
    if (aw_pend || w_pend) begin
      n_cmp++; n_fail++;
      $display("FAIL wr_accept_timeout: pending aw=%0b w=%0b, required both accepted",
               aw_pend, w_pend);
    end
    lat = 0;
    while (!bus.s_bvalid && lat < 20) begin @(negedge clk); lat++; end
    resp = bus.s_bresp;
    @(negedge clk);
    bus.s_bready = 1'b0;
  endtask

  task automatic axi_read(input logic [63:0] a, output logic [31:0] d, output logic [1:0] resp,
                          output int lat);
    int cyc = 0;
    bus.s_araddr  = a;
    bus.s_arvalid = 1'b1;
    bus.s_rready  = 1'b0;
    while (!bus.s_arready && cyc < 20) begin @(negedge clk); cyc++; end
    if (cyc >= 20) begin
      n_cmp++; n_fail++;
      $display("FAIL ar_timeout: arready=%0b, required 1", bus.s_arready);
    end
    @(negedge clk);
    bus.s_arvalid = 1'b0;
    lat = 0;
    while (!bus.s_rvalid && lat < 20) begin @(negedge clk); lat++; end
    d    = bus.s_rdata;
    resp = bus.s_rresp;
    bus.s_rready = 1'b1;
    @(negedge clk);
    bus.s_rready = 1'b0;
  endtask

  task automatic test_reset();
    arst = 1'b0; run = 1'b1;
    bus.s_awaddr = '0; bus.s_awvalid = 1'b0; bus.s_wdata = '0; bus.s_wstrb = '0;
    bus.s_wvalid = 1'b0; bus.s_bready = 1'b0; bus.s_araddr = '0; bus.s_arvalid = 1'b0;
    bus.s_rready = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({bus.s_awready, bus.s_wready, bus.s_arready, bus.s_bvalid, bus.s_rvalid} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_handshake: aw/w/ar/b/r=%b, required 00000",
               {bus.s_awready, bus.s_wready, bus.s_arready, bus.s_bvalid, bus.s_rvalid});
    end
    n_cmp++;
    if (wr_count !== 8'd0) begin
      n_fail++; $display("FAIL reset_count: got %0d, required 0", wr_count);
    end
    arst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({bus.s_awready, bus.s_wready, bus.s_arready} !== 3'b111) begin
      n_fail++;
      $display("FAIL release_ready: aw/w/ar=%b, required 111",
               {bus.s_awready, bus.s_wready, bus.s_arready});
    end
    ref_cnt = 0;
  endtask

  task automatic test_burst();
    logic [1:0] resp;
    logic [31:0] d;
    int lat;
    for (int i = 0; i < 4; i++) begin
      axi_write(64'(4 * i), 32'h1111_1111 * (i + 1), 4'hF, 0, 0, resp, lat);
      ref_write(64'(4 * i), 32'h1111_1111 * (i + 1), 4'hF);
      n_cmp++;
      if (resp !== 2'b00 || lat !== 0) begin
        n_fail++;
        $display("FAIL burst_b[%0d]: resp=%b lat=%0d, required 00 lat=0", i, resp, lat);
      end
    end
    n_cmp++;
    if (wr_count !== 8'd4) begin
      n_fail++; $display("FAIL burst_count: got %0d, required 4", wr_count);
    end
    axi_read(64'h8, d, resp, lat);
    n_cmp++;
    if (d !== 32'h3333_3333 || resp !== 2'b00 || lat !== 0) begin
      n_fail++;
      $display("FAIL burst_read: data=%h resp=%b lat=%0d, required 33333333 00 0", d, resp, lat);
    end
  endtask

  task automatic test_w_before_aw();
    logic [31:0] wd = $urandom;
    logic [31:0] d;
    logic [1:0] resp;
    int lat;
    bus.s_awaddr = 64'h14; bus.s_wdata = wd; bus.s_wstrb = 4'hF;
    bus.s_wvalid = 1'b1; bus.s_bready = 1'b1;
    n_cmp++;
    if (bus.s_wready !== 1'b1) begin
      n_fail++; $display("FAIL wfirst_wready_pre: got %b, required 1", bus.s_wready);
    end
    @(negedge clk);
    bus.s_wvalid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (bus.s_wready !== 1'b0 || bus.s_bvalid !== 1'b0) begin
        n_fail++;
        $display("FAIL wfirst_hold[%0d]: wready=%b bvalid=%b, required 0 0",
                 k, bus.s_wready, bus.s_bvalid);
      end
      @(negedge clk);
    end
    bus.s_awvalid = 1'b1;
    n_cmp++;
    if (bus.s_awready !== 1'b1 || bus.s_wready !== 1'b0) begin
      n_fail++;
      $display("FAIL wfirst_aw_ready: awready=%b wready=%b, required 1 0",
               bus.s_awready, bus.s_wready);
    end
    @(negedge clk);
    bus.s_awvalid = 1'b0;
    n_cmp++;
    if (bus.s_bvalid !== 1'b1 || bus.s_bresp !== 2'b00) begin
      n_fail++;
      $display("FAIL wfirst_b: bvalid=%b bresp=%b, required 1 00", bus.s_bvalid, bus.s_bresp);
    end
    @(negedge clk);
    bus.s_bready = 1'b0;
    ref_write(64'h14, wd, 4'hF);
    n_cmp++;
    if (bus.s_bvalid !== 1'b0) begin
      n_fail++; $display("FAIL wfirst_b_clear: bvalid=%b, required 0", bus.s_bvalid);
    end
    axi_read(64'h14, d, resp, lat);
    n_cmp++;
    if (d !== ref_read(64'h14) || resp !== 2'b00) begin
      n_fail++;
      $display("FAIL wfirst_read: data=%h resp=%b, required %h 00", d, resp, ref_read(64'h14));
    end
  endtask

  task automatic test_out_of_range();
    logic [63:0] addrs [3] = '{64'h40, 64'h2, 64'h0};
    logic [31:0] d;
    logic [1:0] resp;
    int lat;
    for (int i = 0; i < 2; i++) begin
      axi_write(addrs[i], $urandom, 4'hF, 0, 0, resp, lat);
      n_cmp++;
      if (resp !== 2'b10) begin
        n_fail++; $display("FAIL oor_bresp[%0d]: got %b, required 10", i, resp);
      end
    end
    n_cmp++;
    if (wr_count !== 8'(ref_cnt)) begin
      n_fail++; $display("FAIL oor_count: got %0d, required %0d", wr_count, ref_cnt);
    end
    axi_read(addrs[0], d, resp, lat);
    n_cmp++;
    if (d !== 32'h0 || resp !== 2'b10) begin
      n_fail++; $display("FAIL oor_read: data=%h resp=%b, required 00000000 10", d, resp);
    end
    axi_read(addrs[2], d, resp, lat);
    n_cmp++;
    if (d !== ref_read(addrs[2]) || resp !== 2'b00) begin
      n_fail++;
      $display("FAIL oor_word0: data=%h resp=%b, required %h 00", d, resp, ref_read(addrs[2]));
    end
  endtask

  task automatic test_strobe();
    logic [31:0] d;
    logic [1:0] resp;
    int lat;
    axi_write(64'h18, 32'hFFFF_FFFF, 4'hF, 0, 0, resp, lat);
    ref_write(64'h18, 32'hFFFF_FFFF, 4'hF);
    axi_write(64'h18, 32'hAABB_CCDD, 4'b0101, 0, 0, resp, lat);
    ref_write(64'h18, 32'hAABB_CCDD, 4'b0101);
    axi_read(64'h18, d, resp, lat);
    n_cmp++;
    if (d !== 32'hFFBB_FFDD) begin
      n_fail++; $display("FAIL strobe_read: got %h, required ffbbffdd", d);
    end
  endtask

  task automatic test_rw_collision();
    logic [31:0] old_d = $urandom;
    logic [31:0] new_d = ~old_d;
    logic [31:0] d;
    logic [1:0] resp;
    int lat;
    axi_write(64'h10, old_d, 4'hF, 0, 0, resp, lat);
    ref_write(64'h10, old_d, 4'hF);
    bus.s_awaddr = 64'h10; bus.s_wdata = new_d; bus.s_wstrb = 4'hF; bus.s_araddr = 64'h10;
    bus.s_awvalid = 1'b1; bus.s_wvalid = 1'b1; bus.s_arvalid = 1'b1;
    bus.s_bready = 1'b1; bus.s_rready = 1'b0;
    @(negedge clk);
    bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0; bus.s_arvalid = 1'b0;
    n_cmp++;
    if (bus.s_bvalid !== 1'b1 || bus.s_rvalid !== 1'b1 || bus.s_rdata !== old_d) begin
      n_fail++;
      $display("FAIL collide_old: bvalid=%b rvalid=%b data=%h, required 1 1 %h",
               bus.s_bvalid, bus.s_rvalid, bus.s_rdata, old_d);
    end
    bus.s_rready = 1'b1;
    @(negedge clk);
    bus.s_rready = 1'b0; bus.s_bready = 1'b0;
    ref_write(64'h10, new_d, 4'hF);
    axi_read(64'h10, d, resp, lat);
    n_cmp++;
    if (d !== new_d) begin
      n_fail++; $display("FAIL collide_new: got %h, required %h", d, new_d);
    end
  endtask

  task automatic test_bready_stall();
    logic [31:0] wd = $urandom;
    logic [1:0] resp;
    int lat;
    bus.s_awaddr = 64'h1C; bus.s_wdata = wd; bus.s_wstrb = 4'hF;
    bus.s_awvalid = 1'b1; bus.s_wvalid = 1'b1; bus.s_bready = 1'b0;
    @(negedge clk);
    bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0;
    ref_write(64'h1C, wd, 4'hF);
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if (bus.s_bvalid !== 1'b1 || bus.s_bresp !== 2'b00 || bus.s_awready !== 1'b0 ||
          bus.s_wready !== 1'b0) begin
        n_fail++;
        $display("FAIL stall[%0d]: bvalid=%b bresp=%b awready=%b wready=%b, required 1 00 0 0",
                 k, bus.s_bvalid, bus.s_bresp, bus.s_awready, bus.s_wready);
      end
      @(negedge clk);
    end
    bus.s_bready = 1'b1;
    @(negedge clk);
    bus.s_bready = 1'b0;
    n_cmp++;
    if (bus.s_bvalid !== 1'b0 || bus.s_awready !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_release: bvalid=%b awready=%b, required 0 1",
               bus.s_bvalid, bus.s_awready);
    end
    n_cmp++;
    if (wr_count !== 8'(ref_cnt)) begin
      n_fail++; $display("FAIL stall_count: got %0d, required %0d", wr_count, ref_cnt);
    end
    run = 1'b0;
    @(negedge clk);
    run = 1'b1;
    ref_cnt = 0;
    n_cmp++;
    if (wr_count !== 8'd0) begin
      n_fail++; $display("FAIL run_clear: got %0d, required 0", wr_count);
    end
    run = 1'b0;
    axi_write(64'h20, $urandom, 4'hF, 0, 0, resp, lat);
    run = 1'b1;
    n_cmp++;
    if (wr_count !== 8'd0 || resp !== 2'b00) begin
      n_fail++;
      $display("FAIL run_low_write: count=%0d resp=%b, required 0 00", wr_count, resp);
    end
  endtask

  task automatic test_random();
    logic [63:0] a;
    logic [31:0] wd;
    logic [31:0] d;
    logic [3:0]  s;
    logic [1:0]  resp;
    int lat;
    int sel;
    for (int i = 0; i < int'(DEPTH); i++) begin
      wd = $urandom;
      axi_write(64'(4 * i), wd, 4'hF, 0, 0, resp, lat);
      ref_write(64'(4 * i), wd, 4'hF);
    end
    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 9);
      if (sel < 7)       a = 64'($urandom_range(0, 15) * 4);
      else if (sel == 7) a = 64'($urandom_range(16, 24) * 4);
      else if (sel == 8) a = 64'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
      else               a = {32'($urandom), 32'($urandom)} | 64'h1_0000_0000;
      if ($urandom_range(0, 1) == 1) begin
        wd = $urandom;
        s  = 4'($urandom);
        axi_write(a, wd, s, $urandom_range(0, 2), $urandom_range(0, 2), resp, lat);
        ref_write(a, wd, s);
        n_cmp++;
        if (resp !== ref_resp(a) || lat !== 0) begin
          n_fail++;
          $display("FAIL rnd_write[%0d] a=%h: resp=%b lat=%0d, required %b 0",
                   n, a, resp, lat, ref_resp(a));
        end
      end else begin
        axi_read(a, d, resp, lat);
        n_cmp++;
        if (d !== ref_read(a) || resp !== ref_resp(a) || lat !== 0) begin
          n_fail++;
          $display("FAIL rnd_read[%0d] a=%h: data=%h resp=%b lat=%0d, required %h %b 0",
                   n, a, d, resp, lat, ref_read(a), ref_resp(a));
        end
      end
    end
    n_cmp++;
    if (wr_count !== 8'(ref_cnt)) begin
      n_fail++; $display("FAIL rnd_count: got %0d, required %0d", wr_count, ref_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_burst();
    test_w_before_aw();
    test_out_of_range();
    test_strobe();
    test_rw_collision();
    test_bready_stall();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
